// File: rtl/ddr3_word_port.sv
// ddr3_word_port: adapts byte-enabled 32-bit bus reads/writes to whole-line
// reads and read-modify-write sequences on a 256-bit line cache port.
// Optional feature: define DDR3_PORT_LINEBUF_EN to add a one-line buffer
// (read hits served locally, write hits merged and written through).
module ddr3_word_port #(
    parameter int LINE_BYTES = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       bus_addr_i,
    input  logic [31:0]             bus_data_i,
    input  logic [3:0]              bus_sel_i,
    input  logic                    bus_we_i,
    input  logic                    bus_rd_i,
    output logic [31:0]             bus_data_o,
    output logic                    bus_ack_o,
    output logic [ADDR_W-1:0]       line_addr_o,
    output logic [8*LINE_BYTES-1:0] line_data_o,
    input  logic [8*LINE_BYTES-1:0] line_data_i,
    output logic                    line_rd_o,
    output logic                    line_we_o,
    input  logic                    line_ack_i
);

    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int TAG_W  = ADDR_W - 5;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;

    // Word w of a line occupies bits 32w+31:32w.
    function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                             input logic [2:0]        w);
        return line[32*int'(w) +: 32];
    endfunction

    // Replace the enabled bytes of word w with the bus write data.
    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [2:0]        w,
                                                     input logic [31:0]       d,
                                                     input logic [3:0]        sel);
        logic [LINE_W-1:0] m;
        m = line;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                m[32*int'(w) + 8*b +: 8] = d[8*b +: 8];
            end
        end
        return m;
    endfunction

    state_t              r_state, w_state_nxt;
    logic                r_ack, w_ack_nxt;
    logic [31:0]         r_rdata, w_rdata_nxt;
    logic                r_line_rd, w_line_rd_nxt;
    logic                r_line_we, w_line_we_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [LINE_W-1:0]   r_ldata, w_ldata_nxt;
    logic [31:0]         r_wdata, w_wdata_nxt;
    logic [3:0]          r_sel, w_sel_nxt;
    logic                r_is_wr, w_is_wr_nxt;
    logic [2:0]          r_word, w_word_nxt;

    // Byte-offset bits of the bus address carry no meaning for word accesses.
    logic w_unused;
    assign w_unused = &{1'b0, bus_addr_i[1:0]};

`ifdef DDR3_PORT_LINEBUF_EN
    logic                r_buf_vld, w_buf_vld_nxt;
    logic [TAG_W-1:0]    r_buf_tag, w_buf_tag_nxt;
    logic [LINE_W-1:0]   r_buf_data, w_buf_data_nxt;
    logic                w_hit;

    assign w_hit = r_buf_vld && (r_buf_tag == bus_addr_i[ADDR_W-1:5]);
`endif

    assign bus_ack_o   = r_ack;
    assign bus_data_o  = r_rdata;
    assign line_rd_o   = r_line_rd;
    assign line_we_o   = r_line_we;
    assign line_addr_o = r_addr;
    assign line_data_o = r_ldata;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state_nxt   = r_state;
        w_ack_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_line_rd_nxt = r_line_rd;
        w_line_we_nxt = r_line_we;
        w_addr_nxt    = r_addr;
        w_ldata_nxt   = r_ldata;
        w_wdata_nxt   = r_wdata;
        w_sel_nxt     = r_sel;
        w_is_wr_nxt   = r_is_wr;
        w_word_nxt    = r_word;
`ifdef DDR3_PORT_LINEBUF_EN
        w_buf_vld_nxt  = r_buf_vld;
        w_buf_tag_nxt  = r_buf_tag;
        w_buf_data_nxt = r_buf_data;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus_we_i) begin
                    if (bus_sel_i == 4'b0000) begin
                        // Empty write: acknowledge without touching the line.
                        w_state_nxt = S_ACK;
                    end else begin
                        w_addr_nxt  = {bus_addr_i[ADDR_W-1:5], 5'b0};
                        w_word_nxt  = bus_addr_i[4:2];
                        w_wdata_nxt = bus_data_i;
                        w_sel_nxt   = bus_sel_i;
                        w_is_wr_nxt = 1'b1;
`ifdef DDR3_PORT_LINEBUF_EN
                        if (w_hit) begin
                            // Write-through: merge locally, skip the line read.
                            w_ldata_nxt    = merge_word(r_buf_data, bus_addr_i[4:2],
                                                        bus_data_i, bus_sel_i);
                            w_buf_data_nxt = merge_word(r_buf_data, bus_addr_i[4:2],
                                                        bus_data_i, bus_sel_i);
                            w_line_we_nxt  = 1'b1;
                            w_state_nxt    = S_WR;
                        end else begin
                            w_line_rd_nxt = 1'b1;
                            w_state_nxt   = S_RD;
                        end
`else
                        w_line_rd_nxt = 1'b1;
                        w_state_nxt   = S_RD;
`endif
                    end
                end else if (bus_rd_i) begin
                    w_addr_nxt  = {bus_addr_i[ADDR_W-1:5], 5'b0};
                    w_word_nxt  = bus_addr_i[4:2];
                    w_is_wr_nxt = 1'b0;
`ifdef DDR3_PORT_LINEBUF_EN
                    if (w_hit) begin
                        w_rdata_nxt = get_word(r_buf_data, bus_addr_i[4:2]);
                        w_state_nxt = S_ACK;
                    end else begin
                        w_line_rd_nxt = 1'b1;
                        w_state_nxt   = S_RD;
                    end
`else
                    w_line_rd_nxt = 1'b1;
                    w_state_nxt   = S_RD;
`endif
                end
            end
            S_RD: begin
                if (line_ack_i) begin
                    w_line_rd_nxt = 1'b0;
                    if (r_is_wr) begin
                        w_ldata_nxt   = merge_word(line_data_i, r_word, r_wdata, r_sel);
                        w_line_we_nxt = 1'b1;
                        w_state_nxt   = S_WR;
`ifdef DDR3_PORT_LINEBUF_EN
                        w_buf_data_nxt = merge_word(line_data_i, r_word, r_wdata, r_sel);
`endif
                    end else begin
                        w_rdata_nxt = get_word(line_data_i, r_word);
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = S_ACK;
`ifdef DDR3_PORT_LINEBUF_EN
                        w_buf_data_nxt = line_data_i;
`endif
                    end
`ifdef DDR3_PORT_LINEBUF_EN
                    w_buf_vld_nxt = 1'b1;
                    w_buf_tag_nxt = r_addr[ADDR_W-1:5];
`endif
                end
            end
            S_WR: begin
                if (line_ack_i) begin
                    w_line_we_nxt = 1'b0;
                    w_ack_nxt     = 1'b1;
                    w_state_nxt   = S_ACK;
                end
            end
            S_ACK: begin
                // Entered from a line completion the pulse is already up; entered
                // straight from idle it is raised here, one cycle later.
                if (r_ack) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ack_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_line_rd <= 1'b0;
            r_line_we <= 1'b0;
            r_addr    <= '0;
            r_ldata   <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_is_wr   <= 1'b0;
            r_word    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack     <= w_ack_nxt;
            r_rdata   <= w_rdata_nxt;
            r_line_rd <= w_line_rd_nxt;
            r_line_we <= w_line_we_nxt;
            r_addr    <= w_addr_nxt;
            r_ldata   <= w_ldata_nxt;
            r_wdata   <= w_wdata_nxt;
            r_sel     <= w_sel_nxt;
            r_is_wr   <= w_is_wr_nxt;
            r_word    <= w_word_nxt;
        end
    end

`ifdef DDR3_PORT_LINEBUF_EN
    // Line buffer; only the valid bit needs clearing on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_vld <= 1'b0;
        end else begin
            r_buf_vld  <= w_buf_vld_nxt;
            r_buf_tag  <= w_buf_tag_nxt;
            r_buf_data <= w_buf_data_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_word_port.sv
// Directed testbench for ddr3_word_port; honours DDR3_PORT_LINEBUF_EN.
module tb_ddr3_word_port;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  bus_addr_i;
    logic [31:0]  bus_data_i;
    logic [3:0]   bus_sel_i;
    logic         bus_we_i;
    logic         bus_rd_i;
    logic [31:0]  bus_data_o;
    logic         bus_ack_o;
    logic [31:0]  line_addr_o;
    logic [255:0] line_data_o;
    logic [255:0] line_data_i;
    logic         line_rd_o;
    logic         line_we_o;
    logic         line_ack_i;

    int n_vec = 0;
    int n_err = 0;

    ddr3_word_port #(.LINE_BYTES(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_sel_i(bus_sel_i),
        .bus_we_i(bus_we_i), .bus_rd_i(bus_rd_i),
        .bus_data_o(bus_data_o), .bus_ack_o(bus_ack_o),
        .line_addr_o(line_addr_o), .line_data_o(line_data_o), .line_data_i(line_data_i),
        .line_rd_o(line_rd_o), .line_we_o(line_we_o), .line_ack_i(line_ack_i)
    );

    always #5 clk = ~clk;

    // Line whose word k holds base+k.
    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus_we_i = 1'b0; bus_rd_i = 1'b0; line_ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one bus request and plays the cache: each line request is acked
    // in its lat-th high cycle. Cycle 1 is the cycle after the request is sampled.
    task automatic run_access(input logic we, input logic rd, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] sel,
                              input logic [255:0] line, input int lat,
                              output int ack_cyc, output int rd_cnt, output int we_cnt,
                              output int rd_hi, output int ack_cnt, output logic both,
                              output logic [255:0] wline, output logic [31:0] rdata);
        int rd_run, we_run;
        logic prd, pwe;
        ack_cyc = -1; rd_cnt = 0; we_cnt = 0; rd_hi = 0; ack_cnt = 0; both = 1'b0;
        wline = '0; rdata = '0; rd_run = 0; we_run = 0; prd = 1'b0; pwe = 1'b0;
        @(negedge clk);
        bus_addr_i = addr; bus_data_i = data; bus_sel_i = sel; bus_we_i = we; bus_rd_i = rd;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            line_ack_i = 1'b0;
            line_data_i = '0;
            if (line_rd_o && line_we_o) both = 1'b1;
            if (line_rd_o && !prd) rd_cnt++;
            if (line_we_o && !pwe) begin we_cnt++; wline = line_data_o; end
            if (line_rd_o) rd_hi++;
            rd_run = line_rd_o ? rd_run + 1 : 0;
            we_run = line_we_o ? we_run + 1 : 0;
            if (rd_run == lat || we_run == lat) begin line_ack_i = 1'b1; line_data_i = line; end
            if (bus_ack_o) begin
                ack_cnt++;
                if (ack_cyc < 0) begin ack_cyc = c; rdata = bus_data_o; end
                bus_we_i = 1'b0; bus_rd_i = 1'b0;
            end
            prd = line_rd_o; pwe = line_we_o;
            if (ack_cyc >= 0 && c >= ack_cyc + 2) break;
        end
        bus_we_i = 1'b0; bus_rd_i = 1'b0; line_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_addr_i = '0; bus_data_i = '0; bus_sel_i = '0;
        bus_we_i = 1'b0; bus_rd_i = 1'b0; line_data_i = '0; line_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", bus_ack_o); end
        n_vec++; if (bus_data_o !== 32'h0) begin n_err++; $display("FAIL rst_bus_data: got %h want 0", bus_data_o); end
        n_vec++; if (line_rd_o !== 1'b0) begin n_err++; $display("FAIL rst_line_rd: got %b want 0", line_rd_o); end
        n_vec++; if (line_we_o !== 1'b0) begin n_err++; $display("FAIL rst_line_we: got %b want 0", line_we_o); end
        n_vec++; if (line_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_line_addr: got %h want 0", line_addr_o); end
        n_vec++; if (line_data_o !== 256'h0) begin n_err++; $display("FAIL rst_line_data: got %h want 0", line_data_o); end
        rst = 1'b0;
    endtask

    task automatic test_read();
        int ac, rc, wc, rh, an; logic b; logic [255:0] wl; logic [31:0] rdv;
        do_reset();
        run_access(1'b0, 1'b1, 32'h0000_010C, 32'h0, 4'h0, mk_line(32'hA000_0000), 3,
                   ac, rc, wc, rh, an, b, wl, rdv);
        n_vec++; if (rdv !== 32'hA000_0003) begin n_err++; $display("FAIL read_data: got %h want a0000003", rdv); end
        n_vec++; if (line_addr_o !== 32'h0000_0100) begin n_err++; $display("FAIL read_addr: got %h want 00000100", line_addr_o); end
        n_vec++; if (ac !== 4) begin n_err++; $display("FAIL read_ack_latency: got %0d want 4", ac); end
        n_vec++; if (an !== 1) begin n_err++; $display("FAIL read_ack_pulses: got %0d want 1", an); end
        n_vec++; if (rc !== 1) begin n_err++; $display("FAIL read_rd_txn: got %0d want 1", rc); end
        n_vec++; if (wc !== 0) begin n_err++; $display("FAIL read_we_txn: got %0d want 0", wc); end
    endtask

    task automatic test_empty_write();
        int ac, rc, wc, rh, an; logic b; logic [255:0] wl; logic [31:0] rdv;
        run_access(1'b1, 1'b0, 32'h0000_0300, 32'h5555_5555, 4'h0, '1, 3,
                   ac, rc, wc, rh, an, b, wl, rdv);
        n_vec++; if (ac !== 2) begin n_err++; $display("FAIL sel0_ack_latency: got %0d want 2", ac); end
        n_vec++; if (rc !== 0 || wc !== 0) begin n_err++; $display("FAIL sel0_line_traffic: got rd %0d we %0d want 0 0", rc, wc); end
        n_vec++; if (an !== 1) begin n_err++; $display("FAIL sel0_ack_pulses: got %0d want 1", an); end
        n_vec++; if (bus_data_o !== 32'hA000_0003) begin n_err++; $display("FAIL read_data_held: got %h want a0000003", bus_data_o); end
    endtask

    task automatic test_rmw();
        int ac, rc, wc, rh, an; logic b; logic [255:0] wl; logic [31:0] rdv;
        do_reset();
        run_access(1'b1, 1'b0, 32'h0000_0108, 32'h1122_3344, 4'b0101, '1, 3,
                   ac, rc, wc, rh, an, b, wl, rdv);
        n_vec++; if (wl !== 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FF22FF44_FFFFFFFF_FFFFFFFF) begin
            n_err++; $display("FAIL rmw_line: got %h want word2=ff22ff44 rest ffffffff", wl); end
        n_vec++; if (rc !== 1 || wc !== 1) begin n_err++; $display("FAIL rmw_txn: got rd %0d we %0d want 1 1", rc, wc); end
        n_vec++; if (b !== 1'b0) begin n_err++; $display("FAIL rmw_rd_we_overlap: got %b want 0", b); end
        n_vec++; if (ac !== 7) begin n_err++; $display("FAIL rmw_ack_latency: got %0d want 7", ac); end
        n_vec++; if (line_addr_o !== 32'h0000_0100) begin n_err++; $display("FAIL rmw_addr: got %h want 00000100", line_addr_o); end
    endtask

    task automatic test_long_wait();
        int ac, rc, wc, rh, an; logic b; logic [255:0] wl; logic [31:0] rdv;
        do_reset();
        run_access(1'b0, 1'b1, 32'h0000_0414, 32'h0, 4'h0, mk_line(32'h4000_0000), 101,
                   ac, rc, wc, rh, an, b, wl, rdv);
        n_vec++; if (rh !== 101) begin n_err++; $display("FAIL wait_rd_high_cycles: got %0d want 101", rh); end
        n_vec++; if (rc !== 1) begin n_err++; $display("FAIL wait_rd_txn: got %0d want 1", rc); end
        n_vec++; if (ac !== 102) begin n_err++; $display("FAIL wait_ack_latency: got %0d want 102", ac); end
        n_vec++; if (rdv !== 32'h4000_0005) begin n_err++; $display("FAIL wait_data: got %h want 40000005", rdv); end
    endtask

    task automatic test_reset_mid_write();
        int ac, rc, wc, rh, an; logic b; logic [255:0] wl; logic [31:0] rdv;
        logic seen;
        do_reset();
        seen = 1'b0;
        @(negedge clk);
        bus_addr_i = 32'h0000_0500; bus_data_i = 32'h0BAD_F00D; bus_sel_i = 4'hF; bus_we_i = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            line_ack_i = 1'b0;
            if (line_we_o) begin seen = 1'b1; break; end
            if (line_rd_o && c == 3) begin line_ack_i = 1'b1; line_data_i = '0; end
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL mid_reach_wr: got %b want 1", seen); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus_ack_o, line_rd_o, line_we_o} !== 3'b000) begin n_err++;
            $display("FAIL mid_rst_ctrl: got ack/rd/we %b want 000", {bus_ack_o, line_rd_o, line_we_o}); end
        n_vec++; if (line_addr_o !== 32'h0 || line_data_o !== 256'h0 || bus_data_o !== 32'h0) begin n_err++;
            $display("FAIL mid_rst_data: got addr %h data %h rdata %h want all 0", line_addr_o, line_data_o, bus_data_o); end
        rst = 1'b0; bus_we_i = 1'b0;
        run_access(1'b0, 1'b1, 32'h0000_0504, 32'h0, 4'h0, mk_line(32'hD000_0000), 3,
                   ac, rc, wc, rh, an, b, wl, rdv);
        n_vec++; if (rc !== 1) begin n_err++; $display("FAIL mid_fresh_rd_txn: got %0d want 1", rc); end
        n_vec++; if (rdv !== 32'hD000_0001) begin n_err++; $display("FAIL mid_fresh_data: got %h want d0000001", rdv); end
        n_vec++; if (ac !== 4) begin n_err++; $display("FAIL mid_fresh_latency: got %0d want 4", ac); end
    endtask

`ifdef DDR3_PORT_LINEBUF_EN
    task automatic test_linebuf();
        int ac, rc, wc, rh, an; logic b; logic [255:0] wl; logic [31:0] rdv;
        logic [255:0] exp_line;
        do_reset();
        run_access(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'h0, mk_line(32'hB000_0000), 3,
                   ac, rc, wc, rh, an, b, wl, rdv);
        n_vec++; if (rdv !== 32'hB000_0000 || rc !== 1) begin n_err++; $display("FAIL buf_fill: got %h rd %0d want b0000000 1", rdv, rc); end
        run_access(1'b0, 1'b1, 32'h0000_021C, 32'h0, 4'h0, '0, 3,
                   ac, rc, wc, rh, an, b, wl, rdv);
        n_vec++; if (rc !== 0) begin n_err++; $display("FAIL buf_hit_rd_txn: got %0d want 0", rc); end
        n_vec++; if (ac !== 2) begin n_err++; $display("FAIL buf_hit_latency: got %0d want 2", ac); end
        n_vec++; if (rdv !== 32'hB000_0007) begin n_err++; $display("FAIL buf_hit_data: got %h want b0000007", rdv); end
        run_access(1'b1, 1'b0, 32'h0000_0204, 32'hDEAD_BEEF, 4'hF, '0, 3,
                   ac, rc, wc, rh, an, b, wl, rdv);
        exp_line = mk_line(32'hB000_0000);
        exp_line[63:32] = 32'hDEAD_BEEF;
        n_vec++; if (rc !== 0 || wc !== 1) begin n_err++; $display("FAIL buf_whit_txn: got rd %0d we %0d want 0 1", rc, wc); end
        n_vec++; if (wl !== exp_line) begin n_err++; $display("FAIL buf_whit_line: got %h want %h", wl, exp_line); end
        n_vec++; if (ac !== 4) begin n_err++; $display("FAIL buf_whit_latency: got %0d want 4", ac); end
        run_access(1'b0, 1'b1, 32'h0000_0220, 32'h0, 4'h0, mk_line(32'hC000_0000), 3,
                   ac, rc, wc, rh, an, b, wl, rdv);
        n_vec++; if (rc !== 1) begin n_err++; $display("FAIL buf_miss_rd_txn: got %0d want 1", rc); end
        n_vec++; if (rdv !== 32'hC000_0000) begin n_err++; $display("FAIL buf_miss_data: got %h want c0000000", rdv); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_empty_write();
        test_rmw();
        test_long_wait();
        test_reset_mid_write();
`ifdef DDR3_PORT_LINEBUF_EN
        test_linebuf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
